// File: rtl/wave_pkg.sv
// Shared encodings and level constants for the waveform controller.
package wave_pkg;

  localparam int          LEVEL_W    = 12;
  localparam logic [11:0] LEVEL_FULL = 12'd4095;

  // Edit field / FSM state encodings.
  localparam logic [1:0] FIELD_VIEW = 2'd0;
  localparam logic [1:0] FIELD_MAX  = 2'd1;
  localparam logic [1:0] FIELD_MIN  = 2'd2;
  localparam logic [1:0] FIELD_DIV  = 2'd3;

  typedef enum logic [1:0] {
    WAVE_SAW    = 2'd0,
    WAVE_TRI    = 2'd1,
    WAVE_SQUARE = 2'd2,
    WAVE_SINE   = 2'd3
  } wave_e;

  // The edit field cycles through all four encodings.
  function automatic logic [1:0] next_field(input logic [1:0] f);
    return f + 2'd1;
  endfunction

endpackage

// File: rtl/wave_sample_timer.sv
// Per-sample tick generator and sample index counter.
// divider is the value in effect for the next cycle, so a commit edge
// starts the new sample period immediately under the new divider.
module sample_timer
  import wave_pkg::*;
#(
  parameter int N_SAMPLES = 100,
  parameter int IDX_W     = 7,
  parameter int DIV_W     = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [DIV_W-1:0] divider,
  input  logic             load,
  output logic             sample_tick,
  output logic [IDX_W-1:0] sample_idx,
  output logic             wrap
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_SAMPLES - 1);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_next;
  logic             tick_next;

  assign wrap = sample_tick && (sample_idx == IDX_LAST);

  // Counter returns to 0 after the tick cycle; tick is flagged one edge
  // ahead so it is high exactly while the counter sits at divider-1.
  always_comb begin
    cnt_next  = cnt + DIV_W'(1);
    if (sample_tick || load) cnt_next = '0;
    tick_next = (cnt_next == (divider - DIV_W'(1)));
  end

  // Tick counter and registered tick.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt         <= '0;
      sample_tick <= 1'b0;
    end else begin
      cnt         <= cnt_next;
      sample_tick <= tick_next;
    end
  end

  // Sample index advances on every tick and wraps at the last sample.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sample_idx <= '0;
    end else if (sample_tick) begin
      sample_idx <= wrap ? '0 : sample_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/wave_controller.sv
// Waveform settings controller: button-driven edit FSM, shadow settings
// with clamped arithmetic, and commit of all settings at the period wrap.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   VIEW      | up/down cycle the waveform select
//   EDIT_MAX  | up/down step the upper level by AMP_STEP
//   EDIT_MIN  | up/down step the lower level by AMP_STEP
//   EDIT_DIV  | up/down step the sample-rate divider by DIV_STEP
module wave_controller
  import wave_pkg::*;
#(
  parameter int N_SAMPLES = 100,
  parameter int IDX_W     = 7,
  parameter int AMP_STEP  = 64,
  parameter int DIV_W     = 16,
  parameter int DIV_RESET = 1000,
  parameter int DIV_STEP  = 50,
  parameter int DIV_MIN   = 1,
  parameter int DIV_MAX   = 65000
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               btn_mode,
  input  logic               btn_up,
  input  logic               btn_down,
  output logic [LEVEL_W-1:0] maximum,
  output logic [LEVEL_W-1:0] minimum,
  output logic [DIV_W-1:0]   divider,
  output logic [1:0]         wave_sel,
  output logic               sample_tick,
  output logic [IDX_W-1:0]   sample_idx,
  output logic [1:0]         edit_field,
  output logic               pending
);

  localparam logic [LEVEL_W:0]   AMP_X      = (LEVEL_W + 1)'(AMP_STEP);
  localparam logic [LEVEL_W:0]   FULL_X     = {1'b0, LEVEL_FULL};
  localparam logic [DIV_W:0]     DSTEP_X    = (DIV_W + 1)'(DIV_STEP);
  localparam logic [DIV_W:0]     DMIN_X     = (DIV_W + 1)'(DIV_MIN);
  localparam logic [DIV_W:0]     DMAX_X     = (DIV_W + 1)'(DIV_MAX);
  localparam logic [DIV_W-1:0]   DIV_INIT   = DIV_W'(DIV_RESET);

  logic [LEVEL_W-1:0] max_sh, min_sh, max_sh_n, min_sh_n;
  logic [DIV_W-1:0]   div_sh, div_sh_n;
  logic [1:0]         wave_sh, wave_sh_n;
  logic [1:0]         field_n;

  logic               up_ok, down_ok;
  logic [LEVEL_W:0]   max_inc, min_inc;
  logic [DIV_W:0]     div_inc, div_dec_floor;

  logic               wrap;
  logic [DIV_W-1:0]   timer_div;

  logic [LEVEL_W-1:0] max_c_n, min_c_n;
  logic [DIV_W-1:0]   div_c_n;
  logic [1:0]         wave_c_n;

  // Mode wins over up/down; simultaneous up and down cancel out.
  assign up_ok   = btn_up & ~btn_down & ~btn_mode;
  assign down_ok = btn_down & ~btn_up & ~btn_mode;

  // One extra bit of headroom so clamps compare without wrap/underflow.
  assign max_inc       = {1'b0, max_sh} + AMP_X;
  assign min_inc       = {1'b0, min_sh} + AMP_X;
  assign div_inc       = {1'b0, div_sh} + DSTEP_X;
  assign div_dec_floor = DMIN_X + DSTEP_X;

  // Edit FSM and clamped shadow updates; keeps min_sh <= max_sh.
  always_comb begin
    field_n   = edit_field;
    max_sh_n  = max_sh;
    min_sh_n  = min_sh;
    div_sh_n  = div_sh;
    wave_sh_n = wave_sh;
    if (btn_mode) begin
      field_n = next_field(edit_field);
    end else if (up_ok) begin
      case (edit_field)
        FIELD_VIEW: wave_sh_n = wave_sh + 2'd1;
        FIELD_MAX:  max_sh_n  = (max_inc > FULL_X) ? LEVEL_FULL : max_inc[LEVEL_W-1:0];
        FIELD_MIN:  min_sh_n  = (min_inc > {1'b0, max_sh}) ? max_sh : min_inc[LEVEL_W-1:0];
        default:    div_sh_n  = (div_inc > DMAX_X) ? DMAX_X[DIV_W-1:0] : div_inc[DIV_W-1:0];
      endcase
    end else if (down_ok) begin
      case (edit_field)
        FIELD_VIEW: wave_sh_n = wave_sh - 2'd1;
        FIELD_MAX:  max_sh_n  = ({1'b0, max_sh} >= min_inc) ?
                                max_sh - AMP_X[LEVEL_W-1:0] : min_sh;
        FIELD_MIN:  min_sh_n  = ({1'b0, min_sh} >= AMP_X) ?
                                min_sh - AMP_X[LEVEL_W-1:0] : '0;
        default:    div_sh_n  = ({1'b0, div_sh} >= div_dec_floor) ?
                                div_sh - DSTEP_X[DIV_W-1:0] : DMIN_X[DIV_W-1:0];
      endcase
    end
  end

  // Edit state and shadow registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      edit_field <= FIELD_VIEW;
      max_sh     <= LEVEL_FULL;
      min_sh     <= '0;
      div_sh     <= DIV_INIT;
      wave_sh    <= WAVE_SAW;
    end else begin
      edit_field <= field_n;
      max_sh     <= max_sh_n;
      min_sh     <= min_sh_n;
      div_sh     <= div_sh_n;
      wave_sh    <= wave_sh_n;
    end
  end

  // Next committed values: shadows (including this cycle's edit) at a wrap.
  always_comb begin
    max_c_n  = maximum;
    min_c_n  = minimum;
    div_c_n  = divider;
    wave_c_n = wave_sel;
    if (wrap) begin
      max_c_n  = max_sh_n;
      min_c_n  = min_sh_n;
      div_c_n  = div_sh_n;
      wave_c_n = wave_sh_n;
    end
  end

  // Committed settings and pending flag.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      maximum  <= LEVEL_FULL;
      minimum  <= '0;
      divider  <= DIV_INIT;
      wave_sel <= WAVE_SAW;
      pending  <= 1'b0;
    end else begin
      maximum  <= max_c_n;
      minimum  <= min_c_n;
      divider  <= div_c_n;
      wave_sel <= wave_c_n;
      pending  <= (max_sh_n != max_c_n) || (min_sh_n != min_c_n) ||
                  (div_sh_n != div_c_n) || (wave_sh_n != wave_c_n);
    end
  end

  assign timer_div = div_c_n;

  sample_timer #(
    .N_SAMPLES (N_SAMPLES),
    .IDX_W     (IDX_W),
    .DIV_W     (DIV_W)
  ) u_timer (
    .clock       (clock),
    .resetn      (resetn),
    .divider     (timer_div),
    .load        (wrap),
    .sample_tick (sample_tick),
    .sample_idx  (sample_idx),
    .wrap        (wrap)
  );

endmodule

// File: tb/tb_wave_controller.sv
// Bench for wave_controller with a cycle-level settings/timing model.
module tb_wave_controller;

  localparam int N      = 100;
  localparam int BUDGET = 1000;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic [11:0] maximum, minimum;
  logic [15:0] divider;
  logic [1:0]  wave_sel, edit_field;
  logic        sample_tick, pending;
  logic [6:0]  sample_idx;

  int n_total = 0;
  int n_pass  = 0;

  wave_controller #(.DIV_RESET(4)) dut (
    .clock(clock), .resetn(resetn),
    .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
    .maximum(maximum), .minimum(minimum), .divider(divider),
    .wave_sel(wave_sel), .sample_tick(sample_tick), .sample_idx(sample_idx),
    .edit_field(edit_field), .pending(pending)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: committed settings, shadow settings, and sample timing expressed
  // as "cycles left in the current sample" reloaded from the divider.
  int c_max, c_min, c_div, c_wave, s_max, s_min, s_div, s_wave;
  int m_field, m_idx, m_left, m_tick, m_pend;

  function automatic int imin(input int a, input int b); return (a < b) ? a : b; endfunction
  function automatic int imax(input int a, input int b); return (a > b) ? a : b; endfunction

  task automatic model_reset();
    c_max = 4095; c_min = 0; c_div = 4; c_wave = 0;
    s_max = 4095; s_min = 0; s_div = 4; s_wave = 0;
    m_field = 0; m_idx = 0; m_left = 4; m_tick = 0; m_pend = 0;
  endtask

  task automatic model_edge(input logic m, input logic u, input logic d);
    bit wrap;
    wrap = (m_tick == 1) && (m_idx == N - 1);
    if (m) m_field = (m_field + 1) % 4;
    else if (u && !d) begin
      case (m_field)
        0: s_wave = (s_wave + 1) % 4;
        1: s_max  = imin(s_max + 64, 4095);
        2: s_min  = imin(s_min + 64, s_max);
        default: s_div = imin(s_div + 50, 65000);
      endcase
    end else if (d && !u) begin
      case (m_field)
        0: s_wave = (s_wave + 3) % 4;
        1: s_max  = imax(s_max - 64, s_min);
        2: s_min  = imax(s_min - 64, 0);
        default: s_div = imax(s_div - 50, 1);
      endcase
    end
    if (m_tick == 1) m_idx = (m_idx + 1) % N;
    if (wrap) begin
      c_max = s_max; c_min = s_min; c_div = s_div; c_wave = s_wave;
    end
    if (m_left == 1) m_left = c_div;
    else m_left--;
    m_tick = (m_left == 1) ? 1 : 0;
    m_pend = (s_max != c_max || s_min != c_min || s_div != c_div || s_wave != c_wave) ? 1 : 0;
  endtask

  // Per-cycle compare against the model, just after each active edge.
  initial begin
    model_reset();
    forever begin
      @(posedge clock);
      if (!resetn) model_reset();
      else begin
        model_edge(btn_mode, btn_up, btn_down);
        #1;
        if (resetn) begin
          chk("maximum", maximum, c_max);
          chk("minimum", minimum, c_min);
          chk("divider", divider, c_div);
          chk("wave_sel", wave_sel, c_wave);
          chk("sample_tick", sample_tick, m_tick);
          chk("sample_idx", sample_idx, m_idx);
          chk("edit_field", edit_field, m_field);
          chk("pending", pending, m_pend);
        end
      end
    end
  end

  task automatic cyc(input logic m, input logic u, input logic d);
    btn_mode = m; btn_up = u; btn_down = d;
    @(negedge clock);
  endtask

  task automatic presses(input int n, input logic u, input logic d);
    for (int i = 0; i < n; i++) cyc(1'b0, u, d);
  endtask

  // Runs until just after the next period wrap; returns cycles consumed.
  task automatic wait_wrap(output int n);
    n = 0;
    while (!(sample_tick && sample_idx == 7'(N - 1)) && n < BUDGET) begin
      cyc(1'b0, 1'b0, 1'b0);
      n++;
    end
    if (n >= BUDGET) chk("wrap_timeout", n, -1);
    cyc(1'b0, 1'b0, 1'b0);
    n++;
  endtask

  int n;

  initial begin
    repeat (2) @(negedge clock);
    chk("rst_maximum", maximum, 4095);
    chk("rst_minimum", minimum, 0);
    chk("rst_divider", divider, 4);
    chk("rst_wave", wave_sel, 0);
    chk("rst_tick", sample_tick, 0);
    chk("rst_pending", pending, 0);
    resetn = 1'b1;

    // Ticks every 4th cycle; first period ends 400 cycles after release.
    presses(3, 1'b0, 1'b0);
    chk("first_tick", sample_tick, 1);
    wait_wrap(n);
    chk("first_wrap_cycles", n + 3, 400);
    chk("idx_after_wrap", sample_idx, 0);

    // Maximum edits stay in the shadow until the wrap.
    cyc(1'b1, 1'b0, 1'b0);
    presses(3, 1'b0, 1'b1);
    chk("max_pending", pending, 1);
    chk("max_held", maximum, 4095);
    wait_wrap(n);
    chk("max_commit", maximum, 3903);
    chk("max_pending_clr", pending, 0);

    // Bring max to 127, then minimum up x3 clamps at 127.
    presses(60, 1'b0, 1'b1);
    presses(1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    presses(3, 1'b1, 1'b0);
    wait_wrap(n);
    chk("min_commit", minimum, 127);
    chk("max_commit_127", maximum, 127);

    // Max cannot go below min; max saturates at full scale.
    presses(3, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("field_max", edit_field, 1);
    presses(1, 1'b0, 1'b1);
    presses(64, 1'b1, 1'b0);
    chk("sat_pending", pending, 1);
    wait_wrap(n);
    chk("max_sat", maximum, 4095);
    chk("min_kept", minimum, 127);

    // Divider 4 - 50 clamps to 1; up+down together is ignored.
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    presses(1, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    chk("div_held", divider, 4);
    wait_wrap(n);
    chk("div_clamp", divider, 1);
    for (int i = 0; i < 5; i++) begin
      chk("tick_cont", sample_tick, 1);
      cyc(1'b0, 1'b0, 1'b0);
    end

    // Waveform select wraps down 0 -> 3; mode beats up.
    cyc(1'b1, 1'b0, 1'b0);
    chk("field_view", edit_field, 0);
    presses(1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0);
    chk("field_after_mode_up", edit_field, 1);
    wait_wrap(n);
    chk("wave_commit", wave_sel, 3);
    chk("wave_pending_clr", pending, 0);

    // Asynchronous reset mid-period discards pending edits.
    presses(1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("pend_before_rst", pending, 1);
    #2 resetn = 1'b0;
    #1;
    chk("arst_maximum", maximum, 4095);
    chk("arst_minimum", minimum, 0);
    chk("arst_divider", divider, 4);
    chk("arst_wave", wave_sel, 0);
    chk("arst_field", edit_field, 0);
    chk("arst_pending", pending, 0);
    chk("arst_idx", sample_idx, 0);
    @(negedge clock);
    resetn = 1'b1;
    presses(10, 1'b0, 1'b0);
    chk("post_rst_div", divider, 4);
    chk("post_rst_pending", pending, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/wave_controller.md
Name: wave_controller

Overview:
- Sequencing/configuration controller for the function-generator waveform datapath (sawtooth and sibling generators).
- Owns the user-editable settings (maximum, minimum, sample-rate divider, waveform select) driven by button pulses.
- Produces the per-sample enable tick and sample index for the generators.
- Commits edited settings only at a period boundary, so a waveform never changes mid-period.

Parameters:
- N_SAMPLES, 100, samples per waveform period; sample_idx wraps at N_SAMPLES-1.
- IDX_W, 7, width of sample_idx; must satisfy 2^IDX_W >= N_SAMPLES.
- AMP_STEP, 64, increment applied to maximum/minimum per button pulse.
- DIV_W, 16, width of the divider registers.
- DIV_RESET, 1000, divider value loaded at reset.
- DIV_STEP, 50, divider increment per button pulse.
- DIV_MIN, 1, lowest legal divider value.
- DIV_MAX, 65000, highest legal divider value.

Ports:
- clock  in  1  system clock; single clock domain.
- resetn  in  1  asynchronous, active-low reset.
- btn_mode  in  1  one-cycle pulse, already debounced and synchronised; advances the edit field.
- btn_up  in  1  one-cycle pulse; increments the current field.
- btn_down  in  1  one-cycle pulse; decrements the current field.
- maximum  out  12  committed upper level to the generators.
- minimum  out  12  committed lower level to the generators.
- divider  out  DIV_W  committed clocks per sample.
- wave_sel  out  2  committed waveform select: 0=sawtooth, 1=triangle, 2=square, 3=sine.
- sample_tick  out  1  one-cycle sample enable.
- sample_idx  out  IDX_W  current sample index, 0..N_SAMPLES-1.
- edit_field  out  2  FSM state, for display.
- pending  out  1  high when any shadow register differs from its committed value.

Behaviour:
- Reset, asynchronous on resetn low:
  - maximum=4095, minimum=0, divider=DIV_RESET, wave_sel=0.
  - All shadow registers equal their committed values.
  - sample_tick=0, sample_idx=0, tick counter=0, edit_field=VIEW(0), pending=0.
- Edit FSM (edit_field encoding 0..3): VIEW -> EDIT_MAX -> EDIT_MIN -> EDIT_DIV -> VIEW.
  - Each btn_mode pulse advances one state.
  - btn_mode has priority: in a cycle where btn_mode is high, btn_up and btn_down are ignored.
  - btn_up and btn_down high in the same cycle: both ignored.
- Field edits (shadow registers only; the committed outputs are untouched while editing):
  - VIEW: up increments wave_sel_sh mod 4; down decrements it mod 4 (3->0 on up, 0->3 on down).
  - EDIT_MAX, up: max_sh = min(max_sh+AMP_STEP, 4095). Compute at 13 bits, no wrap.
  - EDIT_MAX, down: max_sh = max(max_sh-AMP_STEP, min_sh). Never below min_sh.
  - EDIT_MIN, up: min_sh = min(min_sh+AMP_STEP, max_sh). Never above max_sh.
  - EDIT_MIN, down: min_sh = max(min_sh-AMP_STEP, 0). Signed or 13-bit compare, no underflow.
  - EDIT_DIV: div_sh = div_sh ± DIV_STEP, clamped to [DIV_MIN, DIV_MAX].
  - Invariant: min_sh <= max_sh at all times.
- Tick generator:
  - tick counter runs 0..divider-1.
  - sample_tick is registered and high for exactly one cycle when counter==divider-1; counter returns to 0 on that cycle.
  - divider=1 gives sample_tick high every cycle.
- Sample index: on each sample_tick, sample_idx increments; at N_SAMPLES-1 it wraps to 0.
- Commit point (period wrap): the cycle with sample_tick=1 and sample_idx=N_SAMPLES-1.
  - On that edge, all four shadow registers copy to maximum, minimum, divider and wave_sel.
  - The new values are visible in the same cycle that sample_idx reads 0.
  - The tick counter restarts from 0 under the new divider.
  - An edit landing on the commit cycle itself: the edited value is committed that edge (shadow next-state is used).
- pending is registered: shadow != committed, evaluated after each edge.
- Reset asserted mid-period discards any uncommitted edits.
- The committed outputs change only at reset or at a commit point.

Decomposition:
- Shared package wave_pkg:
  - edit_field encodings (VIEW, EDIT_MAX, EDIT_MIN, EDIT_DIV).
  - wave_sel encodings.
  - 12-bit level width constant and level full-scale constant 4095.
- Sub-module sample_timer: tick counter plus sample_idx counter.
  - Inputs: divider, load.
  - Outputs: sample_tick, sample_idx, wrap.
- The edit FSM, clamp arithmetic and commit logic stay in wave_controller.

Test Plan:
- Reset with DIV_RESET overridden to 4 -> maximum=4095, minimum=0, wave_sel=0; sample_tick every 4th cycle; sample_idx wraps 99->0 after 400 cycles.
- btn_mode once, then btn_down x3 -> pending=1, maximum stays 4095 until the next wrap; at the wrap maximum=3903, pending=0.
- EDIT_MIN with max_sh=100, min_sh=0, btn_up x3 -> min_sh=64, then 100, then 100 (clamped); committed minimum=100 at wrap.
- EDIT_DIV with div=10, btn_down -> clamps to DIV_MIN=1 at commit; sample_tick then continuous; btn_up+btn_down same cycle -> no change.
- VIEW, btn_down at wave_sel=0 -> 3 after commit; btn_mode+btn_up same cycle -> state advances, wave_sel_sh unchanged.
- resetn pulsed low mid-period with edits pending -> all outputs return to reset values immediately (asynchronously), pending=0.
